i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter TGT_ADDR, default 7'h50: 7-bit bus address this target answers to.
REQ-002 Parameter NUM_REGS, default 16: number of byte registers addressed; power of two, 2..256.
REQ-003 iClk  input  1  system clock; frequency SHALL be at least 10x the SCL frequency.
REQ-004 iRst  input  1  reset; synchronous and active-high (already decided).
REQ-005 iSCL  input  1  I2C clock from bus (asynchronous).
REQ-006 iSDA  input  1  I2C data from bus (asynchronous).
REQ-007 oSDAoe  output  1  open-drain control; 0 = drive SDA low, 1 = release.
REQ-008 oRegAddr  output  log2(NUM_REGS)  register pointer.
REQ-009 oRegWrEn  output  1  one-cycle write strobe.
REQ-010 oRegWrData  output  8  write byte, valid with oRegWrEn.
REQ-011 iRegRdData  input  8  byte at oRegAddr, combinational from the register owner.
REQ-012 oBusy  output  1  high from an address match until STOP, or until a START other than the repeated START of the addressed transfer.

Function
REQ-013 iSCL/iSDA SHALL pass a 2-flop synchronizer; all edge, START and STOP detection SHALL use the synchronized values.
REQ-014 START = SDA falls while SCL high; STOP = SDA rises while SCL high; both SHALL be recognised in every state.
REQ-015 Data bits SHALL be sampled on the detected SCL rising edge, MSB first.
REQ-016 oSDAoe SHALL change only on the cycle after a detected SCL falling edge, except that START/STOP release it immediately.
REQ-017 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-018 IDLE -> ADDR on START; ADDR shifts 8 bits (7 address + R/W).
REQ-019 Address match -> ADDR_ACK (drive low for the 9th clock), then PTR if W=0 or RDATA if R=1; mismatch -> IGNORE with SDA released.
REQ-020 PTR: the received byte modulo NUM_REGS SHALL load oRegAddr; ACK; then WDATA.
REQ-021 WDATA: after the 8th bit, pulse oRegWrEn for one cycle with the byte, ACK, then increment oRegAddr.
REQ-022 RDATA: load iRegRdData into the shift register on the SCL falling edge that ends ADDR_ACK or RDATA_ACK; shift out 8 bits; release SDA for the 9th clock.
REQ-023 RDATA_ACK: master ACK (SDA=0) -> increment oRegAddr, then RDATA; master NACK -> IGNORE.
REQ-024 oRegAddr SHALL wrap from NUM_REGS-1 to 0.
REQ-025 Repeated START in any state -> ADDR; oRegAddr retained (supports write-pointer-then-read).
REQ-026 STOP in any state -> IDLE with SDA released; a partially received byte SHALL be discarded with no oRegWrEn.
REQ-027 IGNORE leaves only on START or STOP.
REQ-028 SCL stretching SHALL NOT be performed.

Reset
REQ-029 On iRst: state IDLE, oSDAoe=1, oRegAddr=0, oRegWrEn=0, oRegWrData=0, oBusy=0, bit counters and shift registers 0, synchronizer flops 1.
REQ-030 Reset mid-transfer SHALL release SDA on the next iClk edge and ignore the bus until the next START.

Configuration
REQ-031 Macro I2C_TGT_GLITCH_FILTER_EN: when defined, each synchronized line SHALL pass a 3-sample majority filter, adding 2 cycles of latency and rejecting pulses of 1 iClk; when undefined, the synchronizer output is used directly.

Structure
REQ-032 Shared package i2c_pkg SHALL hold the state enumeration and constants ACK=1'b0 and NACK=1'b1.
REQ-033 Sub-module i2c_line_cond SHALL implement the synchronizer, the optional filter, and rise/fall detection for one line; instantiated twice.

Verification
REQ-034 Write 0x50/W, ptr 0x03, data 0xA5, 0x5A -> ACK on all 4 bytes; strobes at addr 3=0xA5 and addr 4=0x5A.
REQ-035 Write ptr 0x0F then repeated START 0x50/R, master ACK then NACK -> bytes reg[15], reg[0] driven; SDA released after NACK.
REQ-036 Address 0x51/W -> no ACK, oBusy stays 0, no strobe, SDA never driven until the next START.
REQ-037 STOP after 4 bits of a data byte -> no oRegWrEn, state IDLE, oSDAoe=1.
REQ-038 iRst asserted during RDATA with SDA driven low -> oSDAoe=1 next cycle; a following transfer completes normally.
REQ-039 With I2C_TGT_GLITCH_FILTER_EN defined, 1-cycle SCL glitch mid-byte -> bit count unchanged; without the macro the glitch counts as a clock.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: FSM states, bus-level constants and widths.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic ACK       = 1'b0;
  localparam logic NACK      = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one asynchronous I2C line: 2-flop synchronizer, optional 3-sample majority
// filter (I2C_TGT_GLITCH_FILTER_EN) and rise/fall detection.
module i2c_line_cond
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_c,
  output logic rise_c,
  output logic fall_c
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic       line_c;

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [2:0] hist_q, hist_d;

  always_comb begin
    hist_d = {hist_q[1:0], sync_q[1]};
  end

  always_ff @(posedge clk) begin
    if (rst) hist_q <= {3{LINE_IDLE}};
    else     hist_q <= hist_d;
  end

  // Majority of three history samples: a single-cycle pulse never wins the vote
  assign line_c = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
  assign line_c = sync_q[1];
`endif

  always_comb begin
    sync_d = {sync_q[0], line_i};
    prev_d = line_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {2{LINE_IDLE}};
      prev_q <= LINE_IDLE;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_c = line_c;
  assign rise_c  = line_c & ~prev_q;
  assign fall_c  = ~line_c & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target exposing NUM_REGS byte registers behind an auto-incrementing pointer.
// Optional input glitch filter selected with I2C_TGT_GLITCH_FILTER_EN.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TGT_ADDR = 7'h50,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic                        iSCL,
  input  logic                        iSDA,
  output logic                        oSDAoe,
  output logic [$clog2(NUM_REGS)-1:0] oRegAddr,
  output logic                        oRegWrEn,
  output logic [BYTE_W-1:0]           oRegWrData,
  input  logic [BYTE_W-1:0]           iRegRdData,
  output logic                        oBusy
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  logic scl_c, scl_rise_c, scl_fall_c;
  logic sda_c, sda_rise_c, sda_fall_c;
  logic start_c, stop_c, byte_done_c, addr_match_c;

  i2c_state_e state_q, state_d;

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [AW-1:0]     reg_addr_q, reg_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [BYTE_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              mack_q, mack_d;
  logic              sda_oe_q, sda_oe_d;

  i2c_line_cond u_scl_cond (
    .clk     (iClk),
    .rst     (iRst),
    .line_i  (iSCL),
    .level_c (scl_c),
    .rise_c  (scl_rise_c),
    .fall_c  (scl_fall_c)
  );

  i2c_line_cond u_sda_cond (
    .clk     (iClk),
    .rst     (iRst),
    .line_i  (iSDA),
    .level_c (sda_c),
    .rise_c  (sda_rise_c),
    .fall_c  (sda_fall_c)
  );

  assign start_c      = sda_fall_c & scl_c;
  assign stop_c       = sda_rise_c & scl_c;
  assign byte_done_c  = (bit_cnt_q == CNT_W'(8));
  assign addr_match_c = (shift_q[7:1] == TGT_ADDR);

  always_ff @(posedge iClk) begin
    if (iRst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Byte boundaries advance on SCL falling edges so SDA only moves while SCL is low
  always_comb begin
    state_d = state_q;
    if (stop_c) begin
      state_d = IDLE;
    end else if (start_c) begin
      state_d = ADDR;
    end else begin
      case (state_q)
        IDLE:      state_d = IDLE;
        ADDR:      if (scl_fall_c && byte_done_c) state_d = addr_match_c ? ADDR_ACK : IGNORE;
        ADDR_ACK:  if (scl_fall_c) state_d = shift_q[0] ? RDATA : PTR;
        PTR:       if (scl_fall_c && byte_done_c) state_d = PTR_ACK;
        PTR_ACK:   if (scl_fall_c) state_d = WDATA;
        WDATA:     if (scl_fall_c && byte_done_c) state_d = WDATA_ACK;
        WDATA_ACK: if (scl_fall_c) state_d = WDATA;
        RDATA:     if (scl_fall_c && (bit_cnt_q == CNT_W'(7))) state_d = RDATA_ACK;
        RDATA_ACK: if (scl_fall_c) state_d = (mack_q == ACK) ? RDATA : IGNORE;
        IGNORE:    state_d = IGNORE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    reg_addr_d = reg_addr_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    mack_d     = mack_q;
    if (stop_c) begin
      bit_cnt_d = '0;
      shift_d   = '0;
      busy_d    = 1'b0;
    end else if (start_c) begin
      // A repeated START keeps busy and the pointer; an unaddressed START leaves busy low
      bit_cnt_d = '0;
      shift_d   = '0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise_c) begin
            shift_d   = {shift_q[6:0], sda_c};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else if (scl_fall_c && byte_done_c) begin
            bit_cnt_d = '0;
            if (state_q == ADDR) busy_d = addr_match_c;
            if (state_q == PTR)  reg_addr_d = AW'(shift_q);
            if (state_q == WDATA) begin
              wr_en_d   = 1'b1;
              wr_data_d = shift_q;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall_c && shift_q[0]) begin
            shift_d   = iRegRdData;
            bit_cnt_d = '0;
          end
        end
        WDATA_ACK: begin
          if (scl_fall_c) reg_addr_d = reg_addr_q + AW'(1);
        end
        RDATA: begin
          if (scl_fall_c) begin
            if (bit_cnt_q == CNT_W'(7)) begin
              bit_cnt_d = '0;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        RDATA_ACK: begin
          // Advance on the ACK itself so the next byte is valid by the closing fall
          if (scl_rise_c) begin
            mack_d = sda_c;
            if (sda_c == ACK) reg_addr_d = reg_addr_q + AW'(1);
          end else if (scl_fall_c && (mack_q == ACK)) begin
            shift_d   = iRegRdData;
            bit_cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sda_oe_d = NACK;
    case (state_d)
      ADDR_ACK, PTR_ACK, WDATA_ACK: sda_oe_d = ACK;
      RDATA:                        sda_oe_d = shift_d[7];
      default:                      sda_oe_d = NACK;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      reg_addr_q <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      mack_q     <= NACK;
      sda_oe_q   <= 1'b1;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      reg_addr_q <= reg_addr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      mack_q     <= mack_d;
      sda_oe_q   <= sda_oe_d;
    end
  end

  assign oSDAoe     = sda_oe_q;
  assign oRegAddr   = reg_addr_q;
  assign oRegWrEn   = wr_en_q;
  assign oRegWrData = wr_data_q;
  assign oBusy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C master, wired-AND SDA and a 16-byte register model.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int unsigned H = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       oe;
  logic [3:0] addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       busy;

  logic [7:0] regs [16];
  logic [3:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];
  int         n_sda_low = 0;
  int         n_busy = 0;

  int n_pass = 0;
  int n_total = 0;

  assign sda_bus = sda_m & oe;
  assign rd_data = regs[addr];

  i2c_target #(.TGT_ADDR(7'h50), .NUM_REGS(16)) dut (
    .iClk       (clk),
    .iRst       (rst),
    .iSCL       (scl_m),
    .iSDA       (sda_bus),
    .oSDAoe     (oe),
    .oRegAddr   (addr),
    .oRegWrEn   (wr_en),
    .oRegWrData (wr_data),
    .iRegRdData (rd_data),
    .oBusy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] = 8'h30 + 8'(i);
    end else if (wr_en) begin
      wr_addr_q.push_back(addr);
      wr_data_q.push_back(wr_data);
      regs[addr] = wr_data;
    end
    if (!oe) n_sda_low++;
    if (busy) n_busy++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_out(input logic b);
    sda_m = b;
    wait_clks(H / 2);
    scl_m = 1'b1;
    wait_clks(H);
    scl_m = 1'b0;
    wait_clks(H / 2);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_clks(H / 2);
    scl_m = 1'b1;
    wait_clks(H);
    sda_m = 1'b0;
    wait_clks(H);
    scl_m = 1'b0;
    wait_clks(H / 2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_clks(H / 2);
    scl_m = 1'b1;
    wait_clks(H);
    sda_m = 1'b1;
    wait_clks(H);
  endtask

  task automatic ack_clock(output logic ack);
    sda_m = 1'b1;
    wait_clks(H / 2);
    scl_m = 1'b1;
    wait_clks(H / 2);
    ack = sda_bus;
    wait_clks(H / 2);
    scl_m = 1'b0;
    wait_clks(H / 2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    ack_clock(ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clks(H / 2);
      scl_m = 1'b1;
      wait_clks(H / 2);
      b[i] = sda_bus;
      wait_clks(H / 2);
      scl_m = 1'b0;
      wait_clks(H / 2);
    end
    bit_out(mack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb0, rb1;
    int         base, low0, busy0;
    logic [7:0] glitch_byte;

    wait_clks(4);
    chk("rst_sda_oe",   32'(oe), 32'd1);
    chk("rst_addr",     32'(addr), 32'd0);
    chk("rst_wr_en",    32'(wr_en), 32'd0);
    chk("rst_wr_data",  32'(wr_data), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    rst = 1'b0;
    wait_clks(4);

    // Burst write: pointer 3, data A5 then 5A
    base = wr_addr_q.size();
    i2c_start();
    send_byte(8'hA0, ack); chk("wr_addr_ack", 32'(ack), 32'(ACK));
    chk("wr_busy", 32'(busy), 32'd1);
    send_byte(8'h03, ack); chk("wr_ptr_ack", 32'(ack), 32'(ACK));
    send_byte(8'hA5, ack); chk("wr_d0_ack", 32'(ack), 32'(ACK));
    send_byte(8'h5A, ack); chk("wr_d1_ack", 32'(ack), 32'(ACK));
    i2c_stop();
    chk("wr_strobes", 32'(wr_addr_q.size() - base), 32'd2);
    chk("wr_s0_addr", 32'(wr_addr_q[base]), 32'd3);
    chk("wr_s0_data", 32'(wr_data_q[base]), 32'hA5);
    chk("wr_s1_addr", 32'(wr_addr_q[base + 1]), 32'd4);
    chk("wr_s1_data", 32'(wr_data_q[base + 1]), 32'h5A);
    chk("wr_ptr_after", 32'(addr), 32'd5);
    chk("wr_busy_stop", 32'(busy), 32'd0);

    // Pointer 0x0F, repeated START, read with wrap to 0
    base = wr_addr_q.size();
    i2c_start();
    send_byte(8'hA0, ack); chk("rd_waddr_ack", 32'(ack), 32'(ACK));
    send_byte(8'h0F, ack); chk("rd_ptr_ack", 32'(ack), 32'(ACK));
    i2c_start();
    send_byte(8'hA1, ack); chk("rd_raddr_ack", 32'(ack), 32'(ACK));
    recv_byte(ACK, rb0);
    recv_byte(NACK, rb1);
    chk("rd_byte0", 32'(rb0), 32'h3F);
    chk("rd_byte1", 32'(rb1), 32'h30);
    wait_clks(H);
    chk("rd_release", 32'(oe), 32'd1);
    chk("rd_ptr_wrap", 32'(addr), 32'd0);
    chk("rd_busy", 32'(busy), 32'd1);
    i2c_stop();
    chk("rd_busy_stop", 32'(busy), 32'd0);
    chk("rd_no_strobe", 32'(wr_addr_q.size() - base), 32'd0);

    // Foreign address 0x51: target must stay silent
    base = wr_addr_q.size();
    low0 = n_sda_low;
    busy0 = n_busy;
    i2c_start();
    send_byte(8'hA2, ack); chk("na_addr_nack", 32'(ack), 32'(NACK));
    send_byte(8'h11, ack); chk("na_data_nack", 32'(ack), 32'(NACK));
    i2c_stop();
    chk("na_sda_low", 32'(n_sda_low - low0), 32'd0);
    chk("na_busy", 32'(n_busy - busy0), 32'd0);
    chk("na_no_strobe", 32'(wr_addr_q.size() - base), 32'd0);

    // STOP after 4 data bits discards the partial byte
    base = wr_addr_q.size();
    i2c_start();
    send_byte(8'hA0, ack); chk("part_addr_ack", 32'(ack), 32'(ACK));
    send_byte(8'h02, ack); chk("part_ptr_ack", 32'(ack), 32'(ACK));
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1); bit_out(1'b1);
    i2c_stop();
    wait_clks(4);
    chk("part_no_strobe", 32'(wr_addr_q.size() - base), 32'd0);
    chk("part_sda_oe", 32'(oe), 32'd1);
    chk("part_busy", 32'(busy), 32'd0);
    chk("part_state", 32'(dut.state_q), 32'(IDLE));
    chk("part_ptr", 32'(addr), 32'd2);

    // Reset while driving a 0 data bit, then a clean write
    i2c_start();
    send_byte(8'hA0, ack); chk("rr_waddr_ack", 32'(ack), 32'(ACK));
    send_byte(8'h06, ack); chk("rr_ptr_ack", 32'(ack), 32'(ACK));
    i2c_start();
    send_byte(8'hA1, ack); chk("rr_raddr_ack", 32'(ack), 32'(ACK));
    chk("rr_driving", 32'(oe), 32'd0);
    rst = 1'b1;
    wait_clks(1);
    chk("rr_released", 32'(oe), 32'd1);
    chk("rr_ptr", 32'(addr), 32'd0);
    chk("rr_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_clks(4);
    i2c_stop();
    base = wr_addr_q.size();
    i2c_start();
    send_byte(8'hA0, ack); chk("rr2_addr_ack", 32'(ack), 32'(ACK));
    send_byte(8'h07, ack); chk("rr2_ptr_ack", 32'(ack), 32'(ACK));
    send_byte(8'hC3, ack); chk("rr2_data_ack", 32'(ack), 32'(ACK));
    i2c_stop();
    chk("rr2_strobes", 32'(wr_addr_q.size() - base), 32'd1);
    chk("rr2_s_addr", 32'(wr_addr_q[base]), 32'd7);
    chk("rr2_s_data", 32'(wr_data_q[base]), 32'hC3);

    // One-cycle SCL pulse with SDA high after the 4th address bit
    glitch_byte = 8'hA0;
    i2c_start();
    for (int i = 7; i >= 4; i--) bit_out(glitch_byte[i]);
    sda_m = 1'b1;
    wait_clks(4);
    scl_m = 1'b1;
    wait_clks(1);
    scl_m = 1'b0;
    wait_clks(4);
    for (int i = 3; i >= 0; i--) bit_out(glitch_byte[i]);
    ack_clock(ack);
`ifdef I2C_TGT_GLITCH_FILTER_EN
    chk("glitch_ack", 32'(ack), 32'(ACK));
    chk("glitch_busy", 32'(busy), 32'd1);
`else
    chk("glitch_ack", 32'(ack), 32'(NACK));
    chk("glitch_busy", 32'(busy), 32'd0);
`endif
    i2c_stop();
    chk("glitch_busy_stop", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
